// File: rtl/keypad_debounce.sv
// Keypad debounce: turns scan-multiplexed, bouncing one-hot key codes into a held note.
// Optional feature macro KEY_OCTAVE_EN: '*' / '#' presses drive the octave_hi flag.
module keypad_debounce #(
  parameter int HOLD_CYCLES   = 100000,
  parameter int DEBOUNCE_HITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] key_data,
  output logic [7:0]  note_out,
  output logic [3:0]  key_code,
  output logic        key_press,
  output logic        key_release,
  output logic        octave_hi
);

  localparam int GAP_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(HOLD_CYCLES);
  localparam logic [3:0]       HITS     = 4'(DEBOUNCE_HITS);
  localparam logic [3:0]       CODE_NONE = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAND    = 2'd1,
    S_PRESSED = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [11:0]      r_sync1;
  logic [11:0]      r_ks;
  logic [11:0]      r_ks_prev;
  logic [11:0]      r_cand;
  logic [3:0]       r_hit_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [7:0]       r_note;
  logic [3:0]       r_code;
  logic             r_press;
  logic             r_release;

  logic [11:0]      w_cand_nxt;
  logic [3:0]       w_hit_nxt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic [7:0]       w_note_nxt;
  logic [3:0]       w_code_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             w_enter_pressed;

  logic             w_zero;
  logic             w_valid;
  logic             w_match;
  logic             w_hit;
  logic             w_gap_done;
  logic [GAP_W-1:0] w_gap_inc;
  logic [3:0]       w_hit_inc;

  function automatic logic [3:0] f_index(input logic [11:0] v);
    logic [3:0] idx;
    idx = CODE_NONE;
    for (int i = 0; i < 12; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // A hit is the leading edge of the candidate code on the synchronized input,
  // so one scan slot of several cycles counts only once.
  assign w_zero     = (r_ks == 12'd0);
  assign w_valid    = !w_zero && ((r_ks & (r_ks - 12'd1)) == 12'd0);
  assign w_match    = (r_ks == r_cand);
  assign w_hit      = w_match && (r_ks_prev != r_cand);
  assign w_gap_done = w_zero && (r_gap_cnt >= GAP_LAST);
  assign w_gap_inc  = (r_gap_cnt == GAP_MAX) ? r_gap_cnt : r_gap_cnt + GAP_W'(1);
  assign w_hit_inc  = r_hit_cnt + 4'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_cand_nxt      = r_cand;
    w_hit_nxt       = r_hit_cnt;
    w_gap_nxt       = r_gap_cnt;
    w_note_nxt      = r_note;
    w_code_nxt      = r_code;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_enter_pressed = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          w_cand_nxt = r_ks;
          w_hit_nxt  = 4'd1;
          w_gap_nxt  = '0;
          if (DEBOUNCE_HITS <= 1) w_enter_pressed = 1'b1;
          else                    w_state_nxt     = S_CAND;
        end
      end
      S_CAND: begin
        if (w_zero) begin
          if (w_gap_done) begin
            w_state_nxt = S_IDLE;
            w_hit_nxt   = '0;
            w_gap_nxt   = '0;
          end else begin
            w_gap_nxt = w_gap_inc;
          end
        end else if (!w_match) begin
          w_state_nxt = S_IDLE;
          w_hit_nxt   = '0;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = '0;
          if (w_hit) begin
            w_hit_nxt = w_hit_inc;
            if (w_hit_inc >= HITS) w_enter_pressed = 1'b1;
          end
        end
      end
      S_PRESSED: begin
        // A different code ends the hold; IDLE picks it up on the following sample.
        if ((w_zero && w_gap_done) || (!w_zero && !w_match)) begin
          w_state_nxt   = S_IDLE;
          w_note_nxt    = 8'd0;
          w_code_nxt    = CODE_NONE;
          w_release_nxt = 1'b1;
          w_hit_nxt     = '0;
          w_gap_nxt     = '0;
        end else if (w_zero) begin
          w_gap_nxt = w_gap_inc;
        end else begin
          w_gap_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_enter_pressed) begin
      w_state_nxt = S_PRESSED;
      w_note_nxt  = w_cand_nxt[7:0];
      w_code_nxt  = f_index(w_cand_nxt);
      w_press_nxt = 1'b1;
      w_gap_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= '0;
      r_ks      <= '0;
      r_ks_prev <= '0;
      r_cand    <= '0;
      r_hit_cnt <= '0;
      r_gap_cnt <= '0;
      r_note    <= '0;
      r_code    <= CODE_NONE;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= key_data;
      r_ks      <= r_sync1;
      r_ks_prev <= r_ks;
      r_cand    <= w_cand_nxt;
      r_hit_cnt <= w_hit_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_note    <= w_note_nxt;
      r_code    <= w_code_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  assign note_out    = r_note;
  assign key_code    = r_code;
  assign key_press   = r_press;
  assign key_release = r_release;

`ifdef KEY_OCTAVE_EN
  logic r_octave;

  // '*' is bit 9 and '#' is bit 11; the flag survives releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_octave <= 1'b0;
    end else if (w_enter_pressed) begin
      if (w_cand_nxt[9])       r_octave <= 1'b0;
      else if (w_cand_nxt[11]) r_octave <= 1'b1;
    end
  end

  assign octave_hi = r_octave;
`else
  assign octave_hi = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_debounce.sv
// Bench for keypad_debounce: directed scenarios with fixed expectations plus
// randomized scan/bounce traffic checked cycle by cycle against a reference model.
module tb_keypad_debounce;

  localparam int HOLD = 20;
  localparam int HITS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] key_data;
  logic [7:0]  note_out;
  logic [3:0]  key_code;
  logic        key_press;
  logic        key_release;
  logic        octave_hi;

  int n_checks = 0;
  int n_fail   = 0;
  int press_cnt;
  int release_cnt;

`ifdef KEY_OCTAVE_EN
  localparam logic OCT_EN = 1'b1;
`else
  localparam logic OCT_EN = 1'b0;
`endif

  // reference model state
  logic [11:0] m_p1, m_p2, m_prev, m_cand;
  int          m_mode;   // 0 idle, 1 collecting hits, 2 holding
  int          m_hits;
  int          m_zeros;
  logic [7:0]  exp_note;
  logic [3:0]  exp_code;
  logic        exp_press, exp_release, exp_oct;
  logic [11:0] exp_q[$];  // {key_code, note} of each accepted press

  keypad_debounce #(.HOLD_CYCLES(HOLD), .DEBOUNCE_HITS(HITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_data    (key_data),
    .note_out    (note_out),
    .key_code    (key_code),
    .key_press   (key_press),
    .key_release (key_release),
    .octave_hi   (octave_hi)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] bit_index(input logic [11:0] v);
    logic [3:0] r;
    r = 4'd15;
    for (int i = 0; i < 12; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_prev = '0; m_cand = '0;
    m_mode = 0; m_hits = 0; m_zeros = 0;
    exp_note = 8'd0; exp_code = 4'd15;
    exp_press = 1'b0; exp_release = 1'b0; exp_oct = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_accept();
    m_mode    = 2;
    m_zeros   = 0;
    exp_note  = m_cand[7:0];
    exp_code  = bit_index(m_cand);
    exp_press = 1'b1;
    if (OCT_EN && m_cand[9])  exp_oct = 1'b0;
    if (OCT_EN && m_cand[11]) exp_oct = 1'b1;
    exp_q.push_back({exp_code, exp_note});
  endtask

  task automatic model_drop();
    m_mode      = 0;
    exp_note    = 8'd0;
    exp_code    = 4'd15;
    exp_release = 1'b1;
  endtask

  // One processed sample s of the synchronized key stream.
  task automatic model_sample(input logic [11:0] s);
    exp_press   = 1'b0;
    exp_release = 1'b0;
    case (m_mode)
      0: if ($countones(s) == 1) begin
           m_cand = s; m_hits = 1; m_zeros = 0;
           if (HITS == 1) model_accept(); else m_mode = 1;
         end
      1: if (s == 0) begin
           m_zeros++;
           if (m_zeros >= HOLD) m_mode = 0;
         end else if (s != m_cand) begin
           m_mode = 0;
         end else begin
           m_zeros = 0;
           if (m_prev != m_cand) begin
             m_hits++;
             if (m_hits >= HITS) model_accept();
           end
         end
      default: if (s == 0) begin
           m_zeros++;
           if (m_zeros >= HOLD) model_drop();
         end else if (s != m_cand) begin
           model_drop();
         end else begin
           m_zeros = 0;
         end
    endcase
    m_prev = s;
  endtask

  // Drive one cycle of key_data; outputs are observed 1 ns after the edge.
  task automatic tick(input logic [11:0] v);
    key_data = v;
    @(posedge clk);
    #1;
    model_sample(m_p2);
    m_p2 = m_p1;
    m_p1 = v;
    if (key_press)   press_cnt++;
    if (key_release) release_cnt++;
  endtask

  task automatic burst(input logic [11:0] v, input int on_len, input int off_len);
    for (int i = 0; i < on_len; i++)  tick(v);
    for (int i = 0; i < off_len; i++) tick(12'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    key_data = 12'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    press_cnt = 0;
    release_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_data = 12'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (note_out !== 8'h00) begin n_fail++; $display("FAIL reset_note got %h want 00", note_out); end
    n_checks++; if (key_code !== 4'd15) begin n_fail++; $display("FAIL reset_code got %0d want 15", key_code); end
    n_checks++; if (key_press !== 1'b0) begin n_fail++; $display("FAIL reset_press got %b want 0", key_press); end
    n_checks++; if (key_release !== 1'b0) begin n_fail++; $display("FAIL reset_release got %b want 0", key_release); end
    n_checks++; if (octave_hi !== 1'b0) begin n_fail++; $display("FAIL reset_octave got %b want 0", octave_hi); end
    apply_reset();
  endtask

  // Three scan slots of key 1; press must appear on the third cycle of the third slot.
  task automatic test_press();
    logic want;
    apply_reset();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) begin
        tick(12'h001);
        want = (b == 2) && (i == 2);
        n_checks++;
        if (key_press !== want) begin
          n_fail++; $display("FAIL press_timing slot=%0d cyc=%0d got %b want %b", b, i, key_press, want);
        end
      end
      for (int i = 0; i < 8; i++) tick(12'h000);
    end
    n_checks++; if (note_out !== 8'h01) begin n_fail++; $display("FAIL press_note got %h want 01", note_out); end
    n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL press_code got %0d want 0", key_code); end
  endtask

  // Continues from test_press: 8 zero cycles already driven after the last slot.
  task automatic test_release();
    logic want;
    for (int z = 8; z < 30; z++) begin
      tick(12'h000);
      want = (z == 21);
      n_checks++;
      if (key_release !== want) begin
        n_fail++; $display("FAIL release_timing zero=%0d got %b want %b", z, key_release, want);
      end
      if (z == 20) begin
        n_checks++;
        if (note_out !== 8'h01) begin n_fail++; $display("FAIL release_early note got %h want 01", note_out); end
      end
    end
    n_checks++; if (note_out !== 8'h00) begin n_fail++; $display("FAIL release_note got %h want 00", note_out); end
    n_checks++; if (key_code !== 4'd15) begin n_fail++; $display("FAIL release_code got %0d want 15", key_code); end
  endtask

  task automatic test_bounce();
    apply_reset();
    burst(12'h001, 4, 0);
    burst(12'h002, 4, 8);
    n_checks++; if (press_cnt !== 0) begin n_fail++; $display("FAIL bounce_no_press got %0d want 0", press_cnt); end
    n_checks++; if (release_cnt !== 0) begin n_fail++; $display("FAIL bounce_no_release got %0d want 0", release_cnt); end
    for (int b = 0; b < 3; b++) burst(12'h002, 4, 8);
    n_checks++; if (press_cnt !== 1) begin n_fail++; $display("FAIL bounce_press_cnt got %0d want 1", press_cnt); end
    n_checks++; if (note_out !== 8'h02) begin n_fail++; $display("FAIL bounce_note got %h want 02", note_out); end
    n_checks++; if (key_code !== 4'd1) begin n_fail++; $display("FAIL bounce_code got %0d want 1", key_code); end
  endtask

  task automatic test_timeout();
    apply_reset();
    burst(12'h010, 4, 25);
    burst(12'h010, 4, 8);
    burst(12'h010, 4, 8);
    n_checks++; if (press_cnt !== 0) begin n_fail++; $display("FAIL timeout_no_press got %0d want 0", press_cnt); end
    burst(12'h010, 4, 8);
    n_checks++; if (press_cnt !== 1) begin n_fail++; $display("FAIL timeout_press_cnt got %0d want 1", press_cnt); end
    n_checks++; if (note_out !== 8'h10) begin n_fail++; $display("FAIL timeout_note got %h want 10", note_out); end
    n_checks++; if (key_code !== 4'd4) begin n_fail++; $display("FAIL timeout_code got %0d want 4", key_code); end
  endtask

  task automatic test_silent();
    apply_reset();
    for (int b = 0; b < 3; b++) burst(12'h400, 4, 8);
    n_checks++; if (press_cnt !== 1) begin n_fail++; $display("FAIL silent0_press_cnt got %0d want 1", press_cnt); end
    n_checks++; if (key_code !== 4'd10) begin n_fail++; $display("FAIL silent0_code got %0d want 10", key_code); end
    n_checks++; if (note_out !== 8'h00) begin n_fail++; $display("FAIL silent0_note got %h want 00", note_out); end
    burst(12'h000, 0, 25);
    n_checks++; if (release_cnt !== 1) begin n_fail++; $display("FAIL silent0_release got %0d want 1", release_cnt); end
    for (int b = 0; b < 3; b++) burst(12'h800, 4, 8);
    n_checks++; if (key_code !== 4'd11) begin n_fail++; $display("FAIL hash_code got %0d want 11", key_code); end
    n_checks++; if (note_out !== 8'h00) begin n_fail++; $display("FAIL hash_note got %h want 00", note_out); end
    n_checks++; if (octave_hi !== OCT_EN) begin n_fail++; $display("FAIL hash_octave got %b want %b", octave_hi, OCT_EN); end
    burst(12'h000, 0, 25);
    n_checks++; if (key_code !== 4'd15) begin n_fail++; $display("FAIL hash_release_code got %0d want 15", key_code); end
    n_checks++; if (octave_hi !== OCT_EN) begin n_fail++; $display("FAIL octave_hold got %b want %b", octave_hi, OCT_EN); end
    for (int b = 0; b < 3; b++) burst(12'h200, 4, 8);
    n_checks++; if (key_code !== 4'd9) begin n_fail++; $display("FAIL star_code got %0d want 9", key_code); end
    n_checks++; if (octave_hi !== 1'b0) begin n_fail++; $display("FAIL star_octave got %b want 0", octave_hi); end
    n_checks++; if (press_cnt !== 3) begin n_fail++; $display("FAIL silent_press_cnt got %0d want 3", press_cnt); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int b = 0; b < 3; b++) burst(12'h080, 4, 8);
    n_checks++; if (note_out !== 8'h80) begin n_fail++; $display("FAIL mid_held_note got %h want 80", note_out); end
    key_data = 12'h000;
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (note_out !== 8'h00) begin n_fail++; $display("FAIL mid_rst_note got %h want 00", note_out); end
    n_checks++; if (key_code !== 4'd15) begin n_fail++; $display("FAIL mid_rst_code got %0d want 15", key_code); end
    n_checks++; if (key_press !== 1'b0) begin n_fail++; $display("FAIL mid_rst_press got %b want 0", key_press); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++; if (key_release !== 1'b0) begin n_fail++; $display("FAIL mid_rst_release cyc=%0d got %b want 0", i, key_release); end
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick(12'h000);
      n_checks++; if (key_release !== 1'b0) begin n_fail++; $display("FAIL post_rst_release cyc=%0d got %b want 0", i, key_release); end
    end
  endtask

  task automatic rnd_tick(input logic [11:0] v, input int t);
    logic [11:0] got;
    tick(v);
    n_checks++; if (note_out !== exp_note) begin n_fail++; $display("FAIL rnd_note t=%0d got %h want %h", t, note_out, exp_note); end
    n_checks++; if (key_code !== exp_code) begin n_fail++; $display("FAIL rnd_code t=%0d got %0d want %0d", t, key_code, exp_code); end
    n_checks++; if (key_press !== exp_press) begin n_fail++; $display("FAIL rnd_press t=%0d got %b want %b", t, key_press, exp_press); end
    n_checks++; if (key_release !== exp_release) begin n_fail++; $display("FAIL rnd_release t=%0d got %b want %b", t, key_release, exp_release); end
    n_checks++; if (octave_hi !== exp_oct) begin n_fail++; $display("FAIL rnd_octave t=%0d got %b want %b", t, octave_hi, exp_oct); end
    if (key_press) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL rnd_sb t=%0d got press %h want none", t, {key_code, note_out});
      end else begin
        got = exp_q.pop_front();
        if ({key_code, note_out} !== got) begin
          n_fail++; $display("FAIL rnd_sb t=%0d got %h want %h", t, {key_code, note_out}, got);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] keys [14];
    logic [11:0] cur;
    int t;
    int on_len, off_len;
    keys = '{12'h001, 12'h002, 12'h004, 12'h008, 12'h010, 12'h020, 12'h040,
             12'h080, 12'h100, 12'h200, 12'h400, 12'h800, 12'h003, 12'h030};
    apply_reset();
    t = 0;
    cur = keys[0];
    for (int b = 0; b < 160; b++) begin
      if ($urandom_range(0, 3) == 0) cur = keys[$urandom_range(0, 13)];
      on_len  = $urandom_range(1, 4);
      off_len = ($urandom_range(0, 7) == 0) ? $urandom_range(18, 28) : $urandom_range(0, 9);
      for (int i = 0; i < on_len; i++)  begin rnd_tick(cur, t); t++; end
      for (int i = 0; i < off_len; i++) begin rnd_tick(12'h000, t); t++; end
    end
    for (int i = 0; i < 30; i++) begin rnd_tick(12'h000, t); t++; end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rnd_sb_leftover got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    key_data = 12'd0;
    model_reset();
    press_cnt = 0;
    release_cnt = 0;
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_timeout();
    test_silent();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
